gumnut_fetch_unit: RTL
======================

Name: gumnut_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the Gumnut control FSM.
- Owns the program counter and runs the instruction-bus handshake (cyc/stb/ack).
- Latches the 18-bit instruction register (IR) that the FSM decodes, so IR is valid when the FSM enters decode.
- Applies control-flow redirects from the datapath: jump/branch, call and return through an internal return-address stack, interrupt entry, and reti.

Parameters:
- PC_W, 12, program counter / instruction address width.
- IR_W, 18, instruction width.
- RESET_VECTOR, 12'h000, PC value after reset.
- INT_VECTOR, 12'h001, PC loaded on interrupt entry.
- STACK_DEPTH, 8, return-address stack entries (power of two, ≥2).

Ports:
- clk_i  in  1  system clock, all state on rising edge.
- rst_i  in  1  synchronous active-high reset.
- fetch_en_i  in  1  level, high while the FSM is in fetch_state.
- inst_cyc_o  out  1  instruction bus cycle.
- inst_stb_o  out  1  instruction bus strobe.
- inst_adr_o  out  PC_W  instruction address.
- inst_dat_i  in  IR_W  instruction read data.
- inst_ack_i  in  1  bus acknowledge (also observed by the FSM).
- IR_o  out  IR_W  latched instruction.
- ir_pc_o  out  PC_W  address of the instruction held in IR_o.
- pc_o  out  PC_W  current PC (next fetch address).
- jump_i  in  1  load PC from target_i.
- call_i  in  1  push pc_o, then load PC from target_i.
- ret_i  in  1  pop into PC.
- int_i  in  1  push pc_o, then load INT_VECTOR.
- reti_i  in  1  pop into PC.
- target_i  in  PC_W  jump/call target.
- busy_o  out  1  bus transaction in progress.
- cmd_err_o  out  1  one-cycle pulse: command dropped because busy.
- stack_ovf_o  out  1  sticky: push attempted with stack full.
- stack_unf_o  out  1  sticky: pop attempted with stack empty.

Behaviour:
- Reset (rst_i high at an edge), values after that edge:
  - pc_o=RESET_VECTOR; IR_o=0; ir_pc_o=0.
  - inst_cyc_o=inst_stb_o=0; inst_adr_o=0; busy_o=0; cmd_err_o=0.
  - Stack emptied; stack_ovf_o=stack_unf_o=0.
  - Reset wins over everything, including mid-transaction: the bus is abandoned and a late ack is ignored.
- FSM states: IDLE, BUS.
- IDLE:
  - fetch_en_i=1 with no command this cycle → next edge: state=BUS, inst_cyc_o=inst_stb_o=1, inst_adr_o=pc_o, busy_o=1.
- BUS:
  - Outputs held stable until inst_ack_i=1.
  - At the ack edge: IR_o<=inst_dat_i, ir_pc_o<=inst_adr_o, pc_o<=pc_o+1 (modulo 2^PC_W, 4095→0), cyc/stb/busy<=0, state=IDLE.
  - Minimum fetch latency: 2 edges from fetch_en_i rise to IR_o valid (1 to assert stb, 1 for ack).
  - Zero-wait ack is allowed on the first stb cycle.
- IR_o changes only at an ack edge or reset, and is held through decode/execute/mem/write-back.
- Commands (evaluated in IDLE only):
  - Priority when several are high: int_i > call_i > jump_i > ret_i > reti_i. Lower-priority commands that cycle are discarded silently.
  - jump: pc_o<=target_i.
  - call: push pc_o (already incremented, so it is the return address); pc_o<=target_i.
  - int: push pc_o; pc_o<=INT_VECTOR.
  - ret/reti: pc_o<=top of stack; pop.
- Command and fetch_en_i in the same IDLE cycle: the command is applied and no fetch starts. The fetch starts on the next cycle fetch_en_i is high, using the new PC.
- Any command while in BUS: ignored (PC and stack unchanged), cmd_err_o=1 for one cycle.
- Stack full on push: push discarded, PC still loaded with the target/vector, stack_ovf_o<=1.
- Stack empty on pop: pc_o<=0, stack_unf_o<=1.
- Sticky flags clear only on reset.
- Push and pop are never simultaneous, by priority.
- fetch_en_i dropping while in BUS does not cancel the transaction; it completes on ack.

Test Plan:
- Reset, fetch_en_i=1, ack on 1st stb cycle with inst_dat_i=18'h2A5C3 → IR_o=18'h2A5C3, ir_pc_o=0, pc_o=1; stb high exactly 1 cycle.
- Wait states: ack delayed 3 cycles → cyc/stb/inst_adr_o stable for 4 cycles, IR_o unchanged until the ack edge; assert rst_i on cycle 2 instead → outputs zero next edge, late ack ignored.
- pc_o=12'hFFF, fetch with ack → ir_pc_o=12'hFFF, pc_o=0.
- After a fetch at 0x010 (pc_o=0x011): call_i target 0x200 → pc_o=0x200; fetch; ret_i → pc_o=0x011. int_i → pc_o=0x001; reti_i → PC restored.
- 9 consecutive call_i with STACK_DEPTH=8 → stack_ovf_o=1 after the 9th, PC=last target; 9 ret_i → 8 correct addresses, then pc_o=0 and stack_unf_o=1.
- jump_i issued during BUS → cmd_err_o pulse, PC unchanged; int_i+jump_i together in IDLE → pc_o=0x001, one push only.

Source files
------------

// File: rtl/gumnut_fetch_unit.sv
// gumnut_fetch_unit: owns the PC, runs the cyc/stb/ack instruction fetch and latches IR,
// applying jump/call/ret/int/reti redirects through an internal return-address stack.
module gumnut_fetch_unit #(
    parameter int              PC_W         = 12,
    parameter int              IR_W         = 18,
    parameter logic [PC_W-1:0] RESET_VECTOR = 12'h000,
    parameter logic [PC_W-1:0] INT_VECTOR   = 12'h001,
    parameter int              STACK_DEPTH  = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            fetch_en_i,
    output logic            inst_cyc_o,
    output logic            inst_stb_o,
    output logic [PC_W-1:0] inst_adr_o,
    input  logic [IR_W-1:0] inst_dat_i,
    input  logic            inst_ack_i,
    output logic [IR_W-1:0] IR_o,
    output logic [PC_W-1:0] ir_pc_o,
    output logic [PC_W-1:0] pc_o,
    input  logic            jump_i,
    input  logic            call_i,
    input  logic            ret_i,
    input  logic            int_i,
    input  logic            reti_i,
    input  logic [PC_W-1:0] target_i,
    output logic            busy_o,
    output logic            cmd_err_o,
    output logic            stack_ovf_o,
    output logic            stack_unf_o
);
    localparam int SP_W = $clog2(STACK_DEPTH);

    typedef enum logic {IDLE, BUS} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, adr_q, adr_d, ir_pc_q, ir_pc_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [SP_W:0]   sp_q, sp_d, sp_m1;
    logic [PC_W-1:0] stack_q [STACK_DEPTH];
    logic [PC_W-1:0] stack_d [STACK_DEPTH];
    logic            err_q, err_d, ovf_q, ovf_d, unf_q, unf_d;
    logic            any_cmd, push, pop, full, empty;

    assign any_cmd = jump_i | call_i | ret_i | int_i | reti_i;
    assign full    = sp_q == (SP_W+1)'(STACK_DEPTH);
    assign empty   = sp_q == '0;
    assign sp_m1   = sp_q - (SP_W+1)'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        adr_d   = adr_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        sp_d    = sp_q;
        stack_d = stack_q;
        err_d   = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (state_q == BUS) begin
            err_d = any_cmd;
            if (inst_ack_i) begin
                ir_d    = inst_dat_i;
                ir_pc_d = adr_q;
                pc_d    = pc_q + PC_W'(1);
                state_d = IDLE;
            end
        end else if (any_cmd) begin
            // Commands take priority over starting a fetch; only the highest one acts.
            push = int_i | call_i;
            pop  = !push && !jump_i;
            pc_d = int_i ? INT_VECTOR :
                   (call_i | jump_i) ? target_i :
                   empty ? '0 : stack_q[sp_m1[SP_W-1:0]];
            if (push && full) ovf_d = 1'b1;
            if (push && !full) begin
                stack_d[sp_q[SP_W-1:0]] = pc_q;
                sp_d = sp_q + (SP_W+1)'(1);
            end
            if (pop && empty) unf_d = 1'b1;
            if (pop && !empty) sp_d = sp_m1;
        end else if (fetch_en_i) begin
            state_d = BUS;
            adr_d   = pc_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            adr_q   <= '0;
            ir_q    <= '0;
            ir_pc_q <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            adr_q   <= adr_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entries above the stack pointer are don't-care, so the storage needs no reset.
    always_ff @(posedge clk_i) begin
        stack_q <= stack_d;
    end

    assign inst_cyc_o  = state_q == BUS;
    assign inst_stb_o  = state_q == BUS;
    assign busy_o      = state_q == BUS;
    assign inst_adr_o  = adr_q;
    assign IR_o        = ir_q;
    assign ir_pc_o     = ir_pc_q;
    assign pc_o        = pc_q;
    assign cmd_err_o   = err_q;
    assign stack_ovf_o = ovf_q;
    assign stack_unf_o = unf_q;
endmodule
